// File: rtl/car_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// car_sequencer_pkg
// Shared definitions for the CAR microsequencer of the microsequenced MSP430
// core: CAR width, the fixed microsequence entry indices, and the 2-bit
// sequencer state encoding. CarDecoder and the control ROM use the same
// indices, so change them here only.
// -----------------------------------------------------------------------------
package car_sequencer_pkg;

  // Width of the control address (microsequence index).
  localparam int CAR_BITS = 6;

  typedef logic [CAR_BITS-1:0] car_t;

  // Fixed microsequence entry points.
  // CAR_FETCH doubles as CarDecoder's "undefined opcode" answer.
  localparam car_t CAR_FETCH = car_t'(0);
  localparam car_t CAR_RST0  = car_t'(1);
  localparam car_t CAR_INT0  = car_t'(2);
  localparam car_t CAR_MAX   = '1;

  // Sequencer state, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_RST_SEQ = 2'd0,  // running the reset-vector load sequence
    ST_FETCH   = 2'd1,  // car == CAR_FETCH, fetch microword
    ST_EXEC    = 2'd2,  // running an instruction microsequence
    ST_INT_SEQ = 2'd3   // running the interrupt entry sequence
  } seq_state_t;

  // Stepping past the last ROM index is an overrun rather than a wrap.
  function automatic logic car_at_end(input car_t c);
    return (c == CAR_MAX);
  endfunction

  // Interrupts may only be taken at the end of the reset or an instruction
  // sequence, never from fetch or from inside interrupt entry.
  function automatic logic int_allowed(input seq_state_t s);
    return (s == ST_EXEC) || (s == ST_RST_SEQ);
  endfunction

endpackage

// File: rtl/car_sequencer_if.sv
// -----------------------------------------------------------------------------
// car_sequencer_if
// Bundles the sequencer's decode, control-ROM, flow-control and interrupt
// inputs together with its CAR and pulse outputs.
//
// Flow control: there is no valid/ready pair here. stall is the only
// back-pressure: while stall=1 the sequencer is "not ready", CAR and state
// hold and every pulse (iw_load, int_ack, illegal) is forced low. A pulse is
// only meaningful, and only acted on downstream, on a cycle with stall=0.
//
//   master modport : core side (drives decode/ROM/stall/int_req)
//   slave  modport : sequencer side (drives car, pulses and debug state)
// -----------------------------------------------------------------------------
interface car_sequencer_if;
  import car_sequencer_pkg::*;

  car_t       car_decoded;  // start index decoded from the fetch bus word
  logic       ctl_last;     // current microword ends its sequence
  logic       ctl_branch;   // conditional microbranch taken this cycle
  car_t       ctl_target;   // microbranch destination
  logic       stall;        // memory wait state, freezes the sequencer
  logic       int_req;      // maskable interrupt pending (GIE-qualified)

  car_t       car;          // current control address (registered)
  logic       iw_load;      // pulse: latch fetched word into IW
  logic       int_ack;      // pulse: interrupt accepted
  logic       illegal;      // pulse: undefined opcode or microsequence overrun
  seq_state_t state;        // debug view of the sequencer state

  modport master (
    output car_decoded, ctl_last, ctl_branch, ctl_target, stall, int_req,
    input  car, iw_load, int_ack, illegal, state
  );

  modport slave (
    input  car_decoded, ctl_last, ctl_branch, ctl_target, stall, int_req,
    output car, iw_load, int_ack, illegal, state
  );

endinterface

// File: rtl/car_sequencer.sv
// -----------------------------------------------------------------------------
// car_sequencer
// Owns the Control Address Register (CAR). On a fetch it jumps to the start
// index supplied by CarDecoder; between fetches it steps, branches, stalls or
// redirects CAR using control-ROM flags and the interrupt request.
//
// Ports:
//   clk    in   core clock, all state changes on the rising edge
//   rst_n  in   asynchronous active-low reset (car -> CAR_RST0, RST_SEQ)
//   bus    slave modport of car_sequencer_if:
//            car_decoded, ctl_last, ctl_branch, ctl_target, stall, int_req in
//            car (registered), iw_load, int_ack, illegal (combinational),
//            state (debug) out
//
// Next-CAR priority, highest first: stall, fetch, ctl_last, ctl_branch, step.
// -----------------------------------------------------------------------------
module car_sequencer
  import car_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  car_sequencer_if.slave  bus
);

  seq_state_t r_state;
  car_t       r_car;

  seq_state_t w_next_state;
  car_t       w_next_car;
  logic       w_iw_load;
  logic       w_int_ack;
  logic       w_illegal;

  // Decoder answered "undefined": the fetched word is dropped.
  logic w_fetch_undef;
  // Stepping from the top ROM index would run off the end of the ROM.
  logic w_overrun;
  // Interrupt taken at this sequence end.
  logic w_int_take;

  assign w_fetch_undef = (bus.car_decoded == CAR_FETCH);
  assign w_overrun     = car_at_end(r_car);
  assign w_int_take    = bus.int_req && int_allowed(r_state);

  // ---------------------------------------------------------------------------
  // State register (state + CAR)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RST_SEQ;
      r_car   <= CAR_RST0;
    end else begin
      r_state <= w_next_state;
      r_car   <= w_next_car;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-CAR logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_next_car   = r_car;
    if (!bus.stall) begin
      case (r_state)
        ST_FETCH: begin
          // ROM flags are meaningless on the fetch microword.
          if (!w_fetch_undef) begin
            w_next_car   = bus.car_decoded;
            w_next_state = ST_EXEC;
          end
        end
        default: begin
          if (bus.ctl_last) begin
            // ctl_last wins over ctl_branch.
            if (w_int_take) begin
              w_next_car   = CAR_INT0;
              w_next_state = ST_INT_SEQ;
            end else begin
              w_next_car   = CAR_FETCH;
              w_next_state = ST_FETCH;
            end
          end else if (bus.ctl_branch) begin
            w_next_car = bus.ctl_target;
          end else if (w_overrun) begin
            w_next_car   = CAR_FETCH;
            w_next_state = ST_FETCH;
          end else begin
            w_next_car = r_car + car_t'(1);
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output pulses: combinational from state and inputs, low while stalled or
  // held in reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_iw_load = 1'b0;
    w_int_ack = 1'b0;
    w_illegal = 1'b0;
    if (rst_n && !bus.stall) begin
      case (r_state)
        ST_FETCH: begin
          w_iw_load = 1'b1;
          w_illegal = w_fetch_undef;
        end
        default: begin
          if (bus.ctl_last) begin
            w_int_ack = w_int_take;
          end else if (!bus.ctl_branch) begin
            w_illegal = w_overrun;
          end
        end
      endcase
    end
  end

  assign bus.car     = r_car;
  assign bus.iw_load = w_iw_load;
  assign bus.int_ack = w_int_ack;
  assign bus.illegal = w_illegal;
  assign bus.state   = r_state;

endmodule

// File: tb/tb_car_sequencer.sv
// -----------------------------------------------------------------------------
// tb_car_sequencer
// Directed scenarios with literal expectations, then randomized stimulus, all
// checked every cycle against a behavioural model of the CAR sequencing rules.
// -----------------------------------------------------------------------------
module tb_car_sequencer;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  car_sequencer_if bus ();

  car_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: mode of the sequencer and the address it must show.
  // ---------------------------------------------------------------------------
  typedef enum int {M_RST, M_FETCH, M_EXEC, M_INT} mmode_t;

  int     m_car  = 1;
  mmode_t m_mode = M_RST;

  always @(negedge rst_n) begin
    m_car  = 1;
    m_mode = M_RST;
  end

  initial begin : compare_proc
    int     n_car;
    mmode_t n_mode;
    bit     e_iw, e_ack, e_ill;
    forever begin
      @(negedge clk);
      #2;
      e_iw = 0; e_ack = 0; e_ill = 0;
      n_car = m_car; n_mode = m_mode;
      if (!rst_n) begin
        m_car = 1; m_mode = M_RST; n_car = 1; n_mode = M_RST;
      end else if (bus.stall) begin
        // frozen
      end else if (m_mode == M_FETCH) begin
        e_iw = 1;
        if (int'(bus.car_decoded) == 0) e_ill = 1;
        else begin n_car = int'(bus.car_decoded); n_mode = M_EXEC; end
      end else if (bus.ctl_last) begin
        if (m_mode != M_INT && bus.int_req) begin
          e_ack = 1; n_car = 2; n_mode = M_INT;
        end else begin
          n_car = 0; n_mode = M_FETCH;
        end
      end else if (bus.ctl_branch) begin
        n_car = int'(bus.ctl_target);
      end else if (m_car + 1 > 63) begin
        e_ill = 1; n_car = 0; n_mode = M_FETCH;
      end else begin
        n_car = m_car + 1;
      end
      check("model_car",     int'(bus.car),     m_car);
      check("model_iw_load", int'(bus.iw_load), int'(e_iw));
      check("model_int_ack", int'(bus.int_ack), int'(e_ack));
      check("model_illegal", int'(bus.illegal), int'(e_ill));
      @(posedge clk);
      if (!rst_n) begin m_car = 1; m_mode = M_RST; end
      else begin m_car = n_car; m_mode = n_mode; end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  logic s_iw, s_ack, s_ill;

  // Drive one cycle of inputs at the falling edge, capture the pulses mid-cycle,
  // then return just after the rising edge so car can be checked.
  task automatic step(input int dec, input int last, input int br,
                      input int tgt, input int stl, input int intr,
                      input bit rel = 1'b0);
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    bus.car_decoded = 6'(dec);
    bus.ctl_last    = last[0];
    bus.ctl_branch  = br[0];
    bus.ctl_target  = 6'(tgt);
    bus.stall       = stl[0];
    bus.int_req     = intr[0];
    #1;
    s_iw  = bus.iw_load;
    s_ack = bus.int_ack;
    s_ill = bus.illegal;
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    rst_n           = 1'b0;
    bus.car_decoded = '0;
    bus.ctl_last    = 1'b0;
    bus.ctl_branch  = 1'b0;
    bus.ctl_target  = '0;
    bus.stall       = 1'b0;
    bus.int_req     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_car", int'(bus.car), 1);

    // Get to mid-EXEC at car=14.
    step(0, 0, 0, 0, 0, 0, 1'b1);  check("rst_step_car", int'(bus.car), 2);
    step(0, 1, 0, 0, 0, 0);        check("rst_last_car", int'(bus.car), 0);
    step(14, 0, 0, 0, 0, 0);       check("exec14_car",   int'(bus.car), 14);

    // Asynchronous reset mid-EXEC with last+int_req pending.
    bus.ctl_last = 1'b1;
    bus.int_req  = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_car",     int'(bus.car),     1);
    check("async_rst_iw_load", int'(bus.iw_load), 0);
    check("async_rst_int_ack", int'(bus.int_ack), 0);
    check("async_rst_illegal", int'(bus.illegal), 0);
    step(0, 0, 0, 0, 0, 0, 1'b1);  check("rel_car",      int'(bus.car), 2);
    step(0, 1, 0, 0, 0, 0);        check("rel_last_car", int'(bus.car), 0);

    // Two-cycle instruction.
    step(12, 0, 0, 0, 0, 0);
    check("fetch12_iw_load", int'(s_iw), 1);
    check("fetch12_car",     int'(bus.car), 12);
    step(0, 1, 0, 0, 0, 0);        check("single_last_car", int'(bus.car), 0);

    // Multi-step with stall.
    step(20, 0, 0, 0, 0, 0);       check("seq20_car", int'(bus.car), 20);
    step(0, 0, 0, 0, 0, 0);        check("seq21_car", int'(bus.car), 21);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 1, 9, 1, 1);
      check("stall_car",   int'(bus.car), 21);
      check("stall_pulse", int'({s_iw, s_ack, s_ill}), 0);
    end
    step(0, 0, 0, 0, 0, 0);        check("seq22_car", int'(bus.car), 22);
    step(0, 1, 0, 0, 0, 0);        check("seq_last_car", int'(bus.car), 0);

    // Interrupt entry, no nesting.
    step(5, 0, 0, 0, 0, 1);        check("int_exec_car", int'(bus.car), 5);
    step(0, 1, 0, 0, 0, 1);
    check("int_ack_pulse", int'(s_ack), 1);
    check("int_entry_car", int'(bus.car), 2);
    step(0, 0, 0, 0, 0, 1);        check("int_step_car", int'(bus.car), 3);
    step(0, 1, 0, 0, 0, 1);
    check("int_no_nest_ack", int'(s_ack), 0);
    check("int_exit_car",    int'(bus.car), 0);

    // Undefined opcode.
    step(0, 0, 0, 0, 0, 0);
    check("undef_illegal", int'(s_ill), 1);
    check("undef_iw_load", int'(s_iw), 1);
    check("undef_car",     int'(bus.car), 0);

    // Overrun at car=63.
    step(62, 0, 0, 0, 0, 0);       check("ovr62_car", int'(bus.car), 62);
    step(0, 0, 0, 0, 0, 0);        check("ovr63_car", int'(bus.car), 63);
    step(0, 0, 0, 0, 0, 0);
    check("overrun_illegal", int'(s_ill), 1);
    check("overrun_car",     int'(bus.car), 0);

    // Branch, and last overriding branch.
    step(30, 0, 0, 0, 0, 0);       check("br30_car", int'(bus.car), 30);
    step(0, 0, 1, 40, 0, 0);       check("branch_car", int'(bus.car), 40);
    step(0, 1, 1, 50, 0, 0);       check("last_over_branch_car", int'(bus.car), 0);

    // Randomized phase, one asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      int dec, tgt;
      dec = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 63));
      tgt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(56, 63))
                                        : int'($urandom_range(0, 63));
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        step(dec, 0, 0, tgt, 0, 0, 1'b1);
      end else begin
        step(dec,
             int'($urandom_range(0, 3) == 0),
             int'($urandom_range(0, 4) == 0),
             tgt,
             int'($urandom_range(0, 4) == 0),
             int'($urandom_range(0, 2) == 0));
      end
    end

    @(negedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/car_sequencer.md
Name: car_sequencer

Overview:
Microsequencer that owns the Control Address Register (CAR) of the microsequenced MSP430 core. It sits directly downstream of CarDecoder and consumes its decoded microsequence start index on every instruction fetch. Between fetches it steps, branches, stalls or redirects CAR, based on control-ROM flags and on interrupt requests. The CAR output addresses the control ROM.

Parameters:
CAR_BITS, 6, width of the microsequence index; must match the shared CAR_BITS macro.
CAR_FETCH, 0, index of the fetch microword. Also the value CarDecoder returns for undefined opcodes.
CAR_RST0, 1, first microword of the reset-vector load sequence.
CAR_INT0, 2, first microword of the interrupt entry sequence.

Ports:
clk  in  1  core clock; all state updates on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
car_decoded  in  CAR_BITS  start index from CarDecoder. It is decoded from the word currently on the fetch bus.
ctl_last  in  1  control-ROM flag: the current microword ends its sequence.
ctl_branch  in  1  control-ROM flag: conditional microbranch taken this cycle.
ctl_target  in  CAR_BITS  microbranch destination.
stall  in  1  memory wait state; freezes the sequencer.
int_req  in  1  maskable interrupt pending, already qualified by GIE.
car  out  CAR_BITS  current control address.
iw_load  out  1  one-cycle pulse: latch the fetched word into IW.
int_ack  out  1  one-cycle pulse: interrupt accepted.
illegal  out  1  one-cycle pulse: undefined opcode or microsequence overrun.

Behaviour:
- Reset, asynchronous on rst_n low, from any state including mid-sequence:
  - car=CAR_RST0; iw_load=0, int_ack=0, illegal=0.
  - State returns to RST_SEQ.
- States:
  - RST_SEQ: running the reset sequence.
  - FETCH: car==CAR_FETCH.
  - EXEC: running an instruction microsequence.
  - INT_SEQ: running the interrupt entry sequence.
- Next-CAR priority per rising edge, highest first:
  1. stall=1: car and state hold; all pulse outputs 0; ctl_last and ctl_branch ignored.
  2. In FETCH:
     - iw_load=1 this cycle, combinationally, when stall=0.
     - If car_decoded==CAR_FETCH: illegal=1 this cycle; car stays CAR_FETCH, so the word is skipped.
     - Otherwise car<=car_decoded and state becomes EXEC.
     - ctl_last and ctl_branch are ignored in FETCH.
  3. ctl_last=1 in EXEC, RST_SEQ or INT_SEQ:
     - From EXEC or RST_SEQ with int_req=1: car<=CAR_INT0, state INT_SEQ, int_ack=1 this cycle.
     - From INT_SEQ, or when int_req=0: car<=CAR_FETCH, state FETCH.
     - ctl_last overrides ctl_branch when both are set.
  4. ctl_branch=1: car<=ctl_target; state unchanged.
  5. Otherwise car<=car+1.
     - If car is all-ones: no wrap. Instead illegal=1, car<=CAR_FETCH, state FETCH.
- Interrupts:
  - int_req is sampled only on the ctl_last cycle.
  - It is never sampled in FETCH or INT_SEQ, so there is no nested entry mid-sequence.
- Latency:
  - One cycle from fetch to first execute microword.
  - A single-microword instruction (e.g. CAR_REG_REG with ctl_last=1) re-enters FETCH on the next edge, giving 2 cycles per instruction.
- Outputs:
  - car is registered.
  - iw_load, int_ack and illegal are combinational from state and inputs, and are gated by !stall.
- Arithmetic: all CAR arithmetic is unsigned CAR_BITS wide.

Decomposition:
- Shared macros include file, alongside the existing CAR_* indices: CAR_FETCH, CAR_RST0, CAR_INT0, and the state encodings (2-bit: RST_SEQ, FETCH, EXEC, INT_SEQ).
- No sub-module. CarDecoder is instantiated beside this block at core level, not inside it.

Test Plan:
- Reset with rst_n low mid-EXEC (car=14):
  - car=1 immediately, asynchronously; all pulses 0.
  - Release, drive ctl_last on cycle 2 with int_req=0 -> car=0.
- FETCH with car_decoded=12, stall=0:
  - iw_load=1 -> car=12.
  - ctl_last=1 -> car=0 next edge; 2-cycle instruction confirmed.
- Multi-step sequence from 20, stall=1 for 2 cycles at car=21:
  - car=21 held for those 2 cycles, no pulses.
  - Then 22; ctl_last at 22 -> car=0.
- int_req=1 at ctl_last in EXEC:
  - int_ack=1 -> car=2.
  - Hold int_req=1 through INT_SEQ; its ctl_last -> car=0 with no second int_ack.
- FETCH with car_decoded=0 -> illegal=1, iw_load=1, car stays 0.
- Overrun and branch checks:
  - car=63 with no last or branch -> illegal=1, car=0.
  - ctl_branch=1, ctl_target=40 at car=30 -> car=40.
  - ctl_last and ctl_branch together -> car=0.
